// File: rtl/sonar_pkg.sv
// Shared types for the sonar ping/scan path: controller states, angle type and result record.
package sonar_pkg;

  localparam int DEFAULT_ANGLE_WIDTH = 8;
  localparam int DEFAULT_TOF_WIDTH   = 24;

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    BLANK,
    LISTEN,
    REPORT,
    HOLDOFF
  } ping_state_t;

  typedef logic signed [DEFAULT_ANGLE_WIDTH-1:0] angle_t;

  typedef struct packed {
    angle_t                       angle;
    logic [DEFAULT_TOF_WIDTH-1:0] tof;
    logic                         hit;
  } ping_result_t;

endpackage

// File: rtl/angle_sequencer.sv
// Beam angle index for the ping sweep; wraps by default, or bounces end to end
// when PING_SCAN_BOUNCE_EN is defined.
module angle_sequencer
  import sonar_pkg::*;
#(
  parameter int NUM_ANGLES  = 7,
  parameter int ANGLE_MIN   = -30,
  parameter int ANGLE_STEP  = 10,
  parameter int ANGLE_WIDTH = DEFAULT_ANGLE_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          advance_in,
  input  logic                          sweep_en_in,
  output logic signed [ANGLE_WIDTH-1:0] angle_out
);

  localparam int IDX_W = (NUM_ANGLES > 1) ? $clog2(NUM_ANGLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ANGLES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;

`ifdef PING_SCAN_BOUNCE_EN
  logic dir_down_q, dir_down_d;

  // Reverse at either end so no end angle is used on two consecutive pings.
  always_comb begin
    idx_d      = idx_q;
    dir_down_d = dir_down_q;
    if (advance_in && sweep_en_in && (NUM_ANGLES > 1)) begin
      if (!dir_down_q) begin
        if (idx_q == IDX_LAST) begin
          idx_d      = idx_q - 1'b1;
          dir_down_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        if (idx_q == '0) begin
          idx_d      = idx_q + 1'b1;
          dir_down_d = 1'b0;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      dir_down_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      dir_down_q <= dir_down_d;
    end
  end
`else
  always_comb begin
    idx_d = idx_q;
    if (advance_in && sweep_en_in) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end
`endif

  assign angle_out = ANGLE_WIDTH'(ANGLE_MIN + int'(idx_q) * ANGLE_STEP);

endmodule

// File: rtl/ping_scan_controller.sv
// Periodic ping scheduler: burst, blanking, echo confirmation and one result record per ping.
// Optional triangle sweep via PING_SCAN_BOUNCE_EN (handled in angle_sequencer).
module ping_scan_controller
  import sonar_pkg::*;
#(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int BLANK_CYCLES  = 65536,
  parameter int SAMPLE_DIV    = 100,
  parameter int CONFIRM_COUNT = 3,
  parameter int NUM_ANGLES    = 7,
  parameter int ANGLE_MIN     = -30,
  parameter int ANGLE_STEP    = 10,
  parameter int ANGLE_WIDTH   = DEFAULT_ANGLE_WIDTH,
  parameter int DATA_WIDTH    = 16,
  parameter int TOF_WIDTH     = $clog2(PERIOD_CYCLES)
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          enable_in,
  input  logic                          sweep_en_in,
  input  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in,
  input  logic        [DATA_WIDTH-1:0]  threshold_in,
  input  logic        [DATA_WIDTH-1:0]  sample_in,
  input  logic                          sample_valid_in,
  output logic                          burst_out,
  output logic                          burst_start_out,
  output logic                          adc_trigger_out,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          result_valid_out,
  input  logic                          result_ready_in,
  output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
  output logic        [TOF_WIDTH-1:0]   result_tof_out,
  output logic                          result_hit_out,
  output logic                          busy_out
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RUN_W = $clog2(CONFIRM_COUNT + 1);
  localparam logic [TOF_WIDTH-1:0] TIMER_MAX = TOF_WIDTH'(PERIOD_CYCLES - 1);
  localparam logic [TOF_WIDTH-1:0] BURST_END = TOF_WIDTH'(BURST_CYCLES - 1);
  localparam logic [TOF_WIDTH-1:0] BLANK_END = TOF_WIDTH'(BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [RUN_W-1:0]     RUN_LAST  = RUN_W'(CONFIRM_COUNT - 1);

  ping_state_t                   state_q, state_d;
  logic        [TOF_WIDTH-1:0]   timer_q, timer_d;
  logic        [TOF_WIDTH-1:0]   tof_cap_q, tof_cap_d;
  logic        [DIV_W-1:0]       div_q, div_d;
  logic        [RUN_W-1:0]       run_q, run_d;
  logic                          sweep_q, sweep_d;
  logic signed [ANGLE_WIDTH-1:0] beam_angle_q, beam_angle_d;
  logic signed [ANGLE_WIDTH-1:0] res_angle_q, res_angle_d;
  logic        [TOF_WIDTH-1:0]   res_tof_q, res_tof_d;
  logic                          res_hit_q, res_hit_d;
  logic signed [ANGLE_WIDTH-1:0] seq_angle;
  logic                          advance;
  logic                          start_ping;
  logic                          timer_sat;
  logic                          sample_hit;

  angle_sequencer #(
    .NUM_ANGLES (NUM_ANGLES),
    .ANGLE_MIN  (ANGLE_MIN),
    .ANGLE_STEP (ANGLE_STEP),
    .ANGLE_WIDTH(ANGLE_WIDTH)
  ) u_angle_sequencer (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .advance_in (advance),
    .sweep_en_in(sweep_q),
    .angle_out  (seq_angle)
  );

  assign timer_sat  = (timer_q == TIMER_MAX);
  assign sample_hit = sample_valid_in && (sample_in > threshold_in);

  always_comb begin
    state_d          = state_q;
    timer_d          = timer_q;
    tof_cap_d        = tof_cap_q;
    div_d            = div_q;
    run_d            = run_q;
    sweep_d          = sweep_q;
    beam_angle_d     = beam_angle_q;
    res_angle_d      = res_angle_q;
    res_tof_d        = res_tof_q;
    res_hit_d        = res_hit_q;
    advance          = 1'b0;
    start_ping       = 1'b0;
    burst_out        = 1'b0;
    burst_start_out  = 1'b0;
    adc_trigger_out  = 1'b0;
    result_valid_out = 1'b0;

    if ((state_q != IDLE) && !timer_sat) begin
      timer_d = timer_q + 1'b1;
    end

    // One trigger cadence spans BLANK and LISTEN without restarting.
    if ((state_q == BLANK) || (state_q == LISTEN)) begin
      adc_trigger_out = (div_q == '0);
      div_d           = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        timer_d    = '0;
        start_ping = enable_in;
      end
      BURST: begin
        burst_out       = 1'b1;
        burst_start_out = (timer_q == '0);
        run_d           = '0;
        if (timer_q == BURST_END) begin
          state_d = BLANK;
          div_d   = '0;
        end
      end
      BLANK: begin
        if (timer_q == BLANK_END) begin
          state_d = LISTEN;
        end
      end
      LISTEN: begin
        if (sample_valid_in) begin
          if (sample_hit) begin
            run_d = run_q + 1'b1;
            if (run_q == '0) begin
              tof_cap_d = timer_q;
            end
          end else begin
            run_d = '0;
          end
        end
        // Confirmation takes priority over a simultaneous timeout.
        if (sample_hit && (run_q == RUN_LAST)) begin
          state_d     = REPORT;
          res_angle_d = beam_angle_q;
          res_tof_d   = (run_q == '0) ? timer_q : tof_cap_q;
          res_hit_d   = 1'b1;
        end else if (timer_sat) begin
          state_d     = REPORT;
          res_angle_d = beam_angle_q;
          res_tof_d   = '0;
          res_hit_d   = 1'b0;
        end
      end
      REPORT: begin
        result_valid_out = 1'b1;
        if (result_ready_in) begin
          advance = 1'b1;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (timer_sat) begin
          state_d    = IDLE;
          start_ping = enable_in;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_ping) begin
      state_d      = BURST;
      timer_d      = '0;
      sweep_d      = sweep_en_in;
      beam_angle_d = sweep_en_in ? seq_angle : fixed_angle_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      tof_cap_q    <= '0;
      div_q        <= '0;
      run_q        <= '0;
      sweep_q      <= 1'b0;
      beam_angle_q <= '0;
      res_angle_q  <= '0;
      res_tof_q    <= '0;
      res_hit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      tof_cap_q    <= tof_cap_d;
      div_q        <= div_d;
      run_q        <= run_d;
      sweep_q      <= sweep_d;
      beam_angle_q <= beam_angle_d;
      res_angle_q  <= res_angle_d;
      res_tof_q    <= res_tof_d;
      res_hit_q    <= res_hit_d;
    end
  end

  assign beam_angle_out   = beam_angle_q;
  assign result_angle_out = res_angle_q;
  assign result_tof_out   = res_tof_q;
  assign result_hit_out   = res_hit_q;
  assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_ping_scan_controller.sv
// Scoreboard bench for ping_scan_controller with scaled-down timing parameters.
// Honours PING_SCAN_BOUNCE_EN for the expected sweep order.
module tb_ping_scan_controller;

  localparam int PERIOD = 1000;
  localparam int BURST  = 100;
  localparam int BLANK  = 50;
  localparam int DIV    = 10;
  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int TW     = $clog2(PERIOD);

  typedef struct packed {
    logic signed [AW-1:0] angle;
    logic [TW-1:0]        tof;
    logic                 hit;
  } rec_t;

  logic                 clk_in, rst_n, enable_in, sweep_en_in;
  logic signed [AW-1:0] fixed_angle_in;
  logic [DW-1:0]        threshold_in, sample_in;
  logic                 sample_valid_in, result_ready_in;
  logic                 burst_out, burst_start_out, adc_trigger_out;
  logic signed [AW-1:0] beam_angle_out, result_angle_out;
  logic                 result_valid_out, result_hit_out, busy_out;
  logic [TW-1:0]        result_tof_out;

  rec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tb_t = 0;
  int   mode = 0;
  logic trig_d = 1'b0;

  ping_scan_controller #(
    .PERIOD_CYCLES(PERIOD), .BURST_CYCLES(BURST), .BLANK_CYCLES(BLANK),
    .SAMPLE_DIV(DIV), .CONFIRM_COUNT(3), .NUM_ANGLES(3), .ANGLE_MIN(-10),
    .ANGLE_STEP(10), .ANGLE_WIDTH(AW), .DATA_WIDTH(DW), .TOF_WIDTH(TW)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable_in(enable_in), .sweep_en_in(sweep_en_in),
    .fixed_angle_in(fixed_angle_in), .threshold_in(threshold_in), .sample_in(sample_in),
    .sample_valid_in(sample_valid_in), .burst_out(burst_out), .burst_start_out(burst_start_out),
    .adc_trigger_out(adc_trigger_out), .beam_angle_out(beam_angle_out),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_angle_out(result_angle_out), .result_tof_out(result_tof_out),
    .result_hit_out(result_hit_out), .busy_out(busy_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Echo waveform per scenario, indexed by the bench's own copy of the ping timer.
  function automatic logic [DW-1:0] sample_value(input int m, input int t);
    case (m)
      0:       return (t >= 300) ? 16'd6000 : 16'd100;
      1:       return ((t >= 111 && t <= 141) || t == 201 || t == 211 || t >= 401) ? 16'd6000 : 16'd100;
      default: return 16'd5000;
    endcase
  endfunction

  // ADC model: answers each trigger with a valid sample one cycle later.
  initial begin
    sample_valid_in = 1'b0;
    sample_in       = '0;
    forever begin
      @(posedge clk_in);
      #1;
      cyc++;
      if (burst_start_out) tb_t = 0;
      else if (tb_t < PERIOD - 1) tb_t++;
      sample_valid_in = trig_d;
      sample_in       = trig_d ? sample_value(mode, tb_t) : '0;
      trig_d          = adc_trigger_out;
    end
  end

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable_in = 1'b0; result_ready_in = 1'b0;
    sweep_en_in = 1'b1; fixed_angle_in = '0; threshold_in = 16'd5000;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_burst_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = burst_start_out;
    end
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = result_valid_out;
    end
  endtask

  task automatic wait_idle(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = !busy_out;
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    rst_n = 1'b0;
    tick();
    total++;
    if ({burst_out, burst_start_out, adc_trigger_out, result_valid_out, result_hit_out, busy_out} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 000000",
        {burst_out, burst_start_out, adc_trigger_out, result_valid_out, result_hit_out, busy_out});
    end
    total++;
    if (beam_angle_out !== 0 || result_angle_out !== 0 || result_tof_out !== 0) begin
      bad++; $display("[TB] FAIL reset_fields: got beam=%0d angle=%0d tof=%0d want 0 0 0",
        beam_angle_out, result_angle_out, result_tof_out);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    ok = !busy_out && !burst_out;
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL reset_idle: got busy=%b burst=%b want 0 0", busy_out, burst_out);
    end
  endtask

  task automatic test_basic_hit();
    bit seen; int t0, t1, n; rec_t e;
    do_reset();
    mode = 0; result_ready_in = 1'b1;
    exp_q.push_back('{angle: -8'sd10, tof: 10'd301, hit: 1'b1});
    enable_in = 1'b1;
    wait_burst_start(5, seen);
    t0 = cyc;
    total++;
    if (!seen || beam_angle_out !== -8'sd10) begin
      bad++; $display("[TB] FAIL basic_start: seen=%b beam=%0d want 1 -10", seen, beam_angle_out);
    end
    n = 0;
    while (burst_out === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    total++;
    if (n != BURST) begin
      bad++; $display("[TB] FAIL basic_burst_len: got %0d want %0d", n, BURST);
    end
    wait_valid(1100, seen);
    e = exp_q.pop_front();
    total++;
    if (!seen || result_angle_out !== e.angle || result_tof_out !== e.tof || result_hit_out !== e.hit) begin
      bad++; $display("[TB] FAIL basic_rec: got seen=%b angle=%0d tof=%0d hit=%b want %0d %0d %b",
        seen, result_angle_out, result_tof_out, result_hit_out, e.angle, e.tof, e.hit);
    end
    exp_q.push_back('{angle: 8'sd0, tof: 10'd301, hit: 1'b1});
    wait_burst_start(1100, seen);
    t1 = cyc;
    total++;
    if (!seen || t1 - t0 != PERIOD || beam_angle_out !== 8'sd0) begin
      bad++; $display("[TB] FAIL basic_period: got seen=%b delta=%0d beam=%0d want 1 %0d 0",
        seen, t1 - t0, beam_angle_out, PERIOD);
    end
    enable_in = 1'b0;
    wait_valid(1100, seen);
    e = exp_q.pop_front();
    total++;
    if (!seen || result_angle_out !== e.angle || result_tof_out !== e.tof || result_hit_out !== e.hit) begin
      bad++; $display("[TB] FAIL basic_rec2: got seen=%b angle=%0d tof=%0d hit=%b want %0d %0d %b",
        seen, result_angle_out, result_tof_out, result_hit_out, e.angle, e.tof, e.hit);
    end
    wait_idle(1100, seen);
    total++;
    if (!seen || cyc - t1 != PERIOD) begin
      bad++; $display("[TB] FAIL basic_idle: got seen=%b delta=%0d want 1 %0d", seen, cyc - t1, PERIOD);
    end
  endtask

  task automatic test_blank_confirm();
    bit seen, seen2; int t0, t_trig, gap; rec_t e;
    do_reset();
    mode = 1; sweep_en_in = 1'b0; fixed_angle_in = 8'sd25; result_ready_in = 1'b1;
    exp_q.push_back('{angle: 8'sd25, tof: 10'd401, hit: 1'b1});
    enable_in = 1'b1;
    wait_burst_start(5, seen);
    t0 = cyc;
    enable_in = 1'b0;
    total++;
    if (!seen || beam_angle_out !== 8'sd25) begin
      bad++; $display("[TB] FAIL blank_start: seen=%b beam=%0d want 1 25", seen, beam_angle_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = adc_trigger_out;
    end
    t_trig = cyc;
    seen2 = 1'b0;
    for (int i = 0; i < 50 && !seen2; i++) begin
      tick();
      seen2 = adc_trigger_out;
    end
    gap = cyc - t_trig;
    total++;
    if (!seen || !seen2 || t_trig - t0 != BURST || gap != DIV) begin
      bad++; $display("[TB] FAIL blank_trigger: got first=%0d gap=%0d want %0d %0d",
        t_trig - t0, gap, BURST, DIV);
    end
    wait_valid(1100, seen);
    e = exp_q.pop_front();
    total++;
    if (!seen || result_angle_out !== e.angle || result_tof_out !== e.tof || result_hit_out !== e.hit) begin
      bad++; $display("[TB] FAIL blank_rec: got seen=%b angle=%0d tof=%0d hit=%b want %0d %0d %b",
        seen, result_angle_out, result_tof_out, result_hit_out, e.angle, e.tof, e.hit);
    end
    wait_idle(1100, seen);
    total++;
    if (!seen || cyc - t0 != PERIOD) begin
      bad++; $display("[TB] FAIL blank_idle: got seen=%b delta=%0d want 1 %0d", seen, cyc - t0, PERIOD);
    end
  endtask

  task automatic test_timeout();
    bit seen; int t0, ta; rec_t e;
    do_reset();
    mode = 2; sweep_en_in = 1'b0; fixed_angle_in = -8'sd20; result_ready_in = 1'b1;
    exp_q.push_back('{angle: -8'sd20, tof: 10'd0, hit: 1'b0});
    exp_q.push_back('{angle: -8'sd20, tof: 10'd0, hit: 1'b0});
    enable_in = 1'b1;
    wait_burst_start(5, seen);
    t0 = cyc;
    wait_valid(1100, seen);
    ta = cyc;
    e = exp_q.pop_front();
    total++;
    if (!seen || ta - t0 != PERIOD || result_angle_out !== e.angle || result_tof_out !== e.tof ||
        result_hit_out !== e.hit) begin
      bad++; $display("[TB] FAIL timeout_rec: got delta=%0d angle=%0d tof=%0d hit=%b want %0d %0d %0d %b",
        ta - t0, result_angle_out, result_tof_out, result_hit_out, PERIOD, e.angle, e.tof, e.hit);
    end
    wait_burst_start(10, seen);
    total++;
    if (!seen || cyc - ta != 2) begin
      bad++; $display("[TB] FAIL timeout_restart: got seen=%b delta=%0d want 1 2", seen, cyc - ta);
    end
    enable_in = 1'b0;
    wait_valid(1100, seen);
    e = exp_q.pop_front();
    total++;
    if (!seen || result_tof_out !== e.tof || result_hit_out !== e.hit) begin
      bad++; $display("[TB] FAIL timeout_rec2: got seen=%b tof=%0d hit=%b want 1 %0d %b",
        seen, result_tof_out, result_hit_out, e.tof, e.hit);
    end
    wait_idle(1100, seen);
  endtask

  task automatic test_back_pressure();
    bit seen; int rec_bad, burst_bad, busy_bad; rec_t e;
    do_reset();
    mode = 0; sweep_en_in = 1'b1; result_ready_in = 1'b0;
    exp_q.push_back('{angle: -8'sd10, tof: 10'd301, hit: 1'b1});
    enable_in = 1'b1;
    wait_burst_start(5, seen);
    wait_valid(1100, seen);
    e = exp_q[0];
    rec_bad = seen ? 0 : 1;
    burst_bad = 0;
    busy_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if (result_valid_out !== 1'b1 || result_angle_out !== e.angle || result_tof_out !== e.tof ||
          result_hit_out !== e.hit) rec_bad++;
      if (burst_out !== 1'b0) burst_bad++;
      if (busy_out !== 1'b1) busy_bad++;
      tick();
    end
    total++;
    if (rec_bad != 0) begin
      bad++; $display("[TB] FAIL bp_record: got %0d unstable cycles want 0", rec_bad);
    end
    total++;
    if (burst_bad != 0 || busy_bad != 0) begin
      bad++; $display("[TB] FAIL bp_stall: got burst=%0d busy_low=%0d cycles want 0 0", burst_bad, busy_bad);
    end
    result_ready_in = 1'b1;
    void'(exp_q.pop_front());
    tick();
    result_ready_in = 1'b0;
    exp_q.push_back('{angle: 8'sd0, tof: 10'd301, hit: 1'b1});
    wait_burst_start(10, seen);
    enable_in = 1'b0;
    total++;
    if (!seen || beam_angle_out !== 8'sd0) begin
      bad++; $display("[TB] FAIL bp_next_angle: got seen=%b beam=%0d want 1 0", seen, beam_angle_out);
    end
    result_ready_in = 1'b1;
    wait_valid(1100, seen);
    e = exp_q.pop_front();
    total++;
    if (!seen || result_angle_out !== e.angle || result_tof_out !== e.tof || result_hit_out !== e.hit) begin
      bad++; $display("[TB] FAIL bp_rec2: got seen=%b angle=%0d tof=%0d hit=%b want %0d %0d %b",
        seen, result_angle_out, result_tof_out, result_hit_out, e.angle, e.tof, e.hit);
    end
    wait_idle(1100, seen);
  endtask

  task automatic test_sweep_order();
    bit seen; int exp_ang[5]; rec_t e;
`ifdef PING_SCAN_BOUNCE_EN
    exp_ang = '{-10, 0, 10, 0, -10};
`else
    exp_ang = '{-10, 0, 10, -10, 0};
`endif
    do_reset();
    mode = 0; sweep_en_in = 1'b1; result_ready_in = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back('{angle: AW'(exp_ang[k]), tof: 10'd301, hit: 1'b1});
    enable_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(1100, seen);
      if (k == 4) enable_in = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (!seen || result_angle_out !== e.angle || result_hit_out !== e.hit) begin
        bad++; $display("[TB] FAIL sweep_angle_%0d: got seen=%b angle=%0d hit=%b want %0d %b",
          k, seen, result_angle_out, result_hit_out, e.angle, e.hit);
      end
    end
    wait_idle(1100, seen);
  endtask

  task automatic test_async_reset();
    bit seen; rec_t e;
    do_reset();
    mode = 0; sweep_en_in = 1'b1; result_ready_in = 1'b1;
    enable_in = 1'b1;
    wait_burst_start(5, seen);
    repeat (200) tick();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({burst_out, adc_trigger_out, result_valid_out, busy_out} !== 4'b0 || beam_angle_out !== 0) begin
      bad++; $display("[TB] FAIL areset_now: got flags=%b beam=%0d want 0000 0",
        {burst_out, adc_trigger_out, result_valid_out, busy_out}, beam_angle_out);
    end
    repeat (3) tick();
    total++;
    if (busy_out !== 1'b0 || burst_out !== 1'b0) begin
      bad++; $display("[TB] FAIL areset_idle: got busy=%b burst=%b want 0 0", busy_out, burst_out);
    end
    rst_n = 1'b1;
    exp_q.push_back('{angle: -8'sd10, tof: 10'd301, hit: 1'b1});
    wait_burst_start(5, seen);
    enable_in = 1'b0;
    total++;
    if (!seen || beam_angle_out !== -8'sd10) begin
      bad++; $display("[TB] FAIL areset_angle: got seen=%b beam=%0d want 1 -10", seen, beam_angle_out);
    end
    wait_valid(1100, seen);
    e = exp_q.pop_front();
    total++;
    if (!seen || result_angle_out !== e.angle || result_tof_out !== e.tof || result_hit_out !== e.hit) begin
      bad++; $display("[TB] FAIL areset_rec: got seen=%b angle=%0d tof=%0d hit=%b want %0d %0d %b",
        seen, result_angle_out, result_tof_out, result_hit_out, e.angle, e.tof, e.hit);
    end
    wait_idle(1100, seen);
  endtask

  initial begin
    rst_n = 1'b0; enable_in = 1'b0; sweep_en_in = 1'b1; fixed_angle_in = '0;
    threshold_in = 16'd5000; result_ready_in = 1'b0;
    test_reset();
    test_basic_hit();
    test_blank_confirm();
    test_timeout();
    test_back_pressure();
    test_sweep_order();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ping_scan_controller.md
Name: ping_scan_controller

Overview:
- Parametrised successor to the fixed single-angle ping/echo timing in the sonar top level.
- Schedules periodic transmit bursts and steps the beam angle across a configurable sweep.
- Generates ADC sample triggers, applies a post-burst blanking window, and confirms echoes over several consecutive samples against a runtime threshold.
- Emits one {angle, time-of-flight, hit} record per ping over a valid/ready handshake, which feeds the range and display logic.

Parameters:
- PERIOD_CYCLES, 16777216, ping period in clk_in cycles (ping start to earliest next ping start).
- BURST_CYCLES, 524288, cycles burst_out stays high per ping.
- BLANK_CYCLES, 65536, cycles after the burst during which samples are ignored (ringdown).
- SAMPLE_DIV, 100, clk_in cycles between adc_trigger_out pulses.
- CONFIRM_COUNT, 3, consecutive above-threshold valid samples needed to declare an echo (≥1).
- NUM_ANGLES, 7, sweep steps (≥1).
- ANGLE_MIN, -30, signed degrees at index 0.
- ANGLE_STEP, 10, signed degrees per index.
- ANGLE_WIDTH, 8, beam angle width (signed).
- DATA_WIDTH, 16, sample width (unsigned).
- TOF_WIDTH, $clog2(PERIOD_CYCLES), timer/time-of-flight width.

Ports:
- clk_in  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable_in  in  1  run pings while high.
- sweep_en_in  in  1  1 = step angle per ping; 0 = hold fixed_angle_in.
- fixed_angle_in  in  ANGLE_WIDTH  signed angle used when sweep_en_in=0.
- threshold_in  in  DATA_WIDTH  echo threshold (strictly-greater compare).
- sample_in  in  DATA_WIDTH  aggregated receive waveform.
- sample_valid_in  in  1  sample_in qualifier.
- burst_out  out  1  transmitter gate.
- burst_start_out  out  1  one-cycle pulse on first burst cycle.
- adc_trigger_out  out  1  one-cycle ADC conversion request.
- beam_angle_out  out  ANGLE_WIDTH  signed angle for the current ping; stable for the whole ping.
- result_valid_out  out  1  result record valid.
- result_ready_in  in  1  consumer accepts the record.
- result_angle_out  out  ANGLE_WIDTH  angle of the reported ping.
- result_tof_out  out  TOF_WIDTH  cycles from burst start to the first sample of the confirming run.
- result_hit_out  out  1  1 = echo confirmed, 0 = timeout.
- busy_out  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, timer=0, angle index=0, direction=up.
  - All outputs 0; beam_angle_out=0.
- States: IDLE, BURST, BLANK, LISTEN, REPORT, HOLDOFF.
- IDLE:
  - enable_in=1 → BURST next cycle.
  - beam_angle_out latched at this transition: sweep_en_in ? ANGLE_MIN+idx*ANGLE_STEP : fixed_angle_in.
- Timer:
  - Reads 0 in the first BURST cycle and increments every cycle thereafter.
  - Saturates at PERIOD_CYCLES-1.
- BURST:
  - burst_out=1; burst_start_out=1 only in the first cycle.
  - At timer=BURST_CYCLES-1 → BLANK.
- BLANK:
  - adc_trigger_out pulses every SAMPLE_DIV cycles, first pulse on the first BLANK cycle.
  - Incoming samples are ignored.
  - At timer=BURST_CYCLES+BLANK_CYCLES-1 → LISTEN.
- LISTEN:
  - Trigger cadence continues unbroken from BLANK.
  - On sample_valid_in with sample_in>threshold_in: run counter increments; the first sample of a run captures the current timer value.
  - On sample_valid_in with sample_in≤threshold_in: run counter clears.
  - Run counter reaching CONFIRM_COUNT → REPORT with hit=1 and tof=captured value.
  - Timer reaching PERIOD_CYCLES-1 without confirmation → REPORT with hit=0 and tof=0.
  - If confirmation and timeout occur in the same cycle, hit wins.
- REPORT:
  - result_valid_out=1 with fields stable until result_valid_out && result_ready_in.
  - On acceptance: advance the angle index (only if sweep_en_in=1), then → HOLDOFF.
  - Timer keeps running and saturating.
- HOLDOFF:
  - Waits until timer=PERIOD_CYCLES-1, then → BURST if enable_in=1, else IDLE.
  - If the timer is already saturated on entry, the transition happens on the next cycle.
- Sweep index without the optional feature: wraps N-1→0.
- adc_trigger_out is 0 in IDLE, BURST, REPORT and HOLDOFF.
- enable_in dropping mid-ping does not abort the ping; the record is still delivered.
- sweep_en_in and fixed_angle_in are sampled only at ping start.
- Back-pressure: the next ping never starts before its record is accepted, so no records are dropped.
- NUM_ANGLES=1: index stays 0.

Optional Feature:
- Macro PING_SCAN_BOUNCE_EN.
- Defined: triangle sweep that reverses direction at both ends, giving index order 0,1,…,N-1,N-2,…,1,0,1,…
  - No end angle is repeated on consecutive pings.
  - A direction register resets to up.
- Undefined: wrap sweep only, and no direction register exists.

Decomposition:
- sonar_pkg holds:
  - ping_state_t enum (six states).
  - ANGLE_WIDTH default.
  - signed angle typedef.
  - result record struct {angle, tof, hit}.
- One sub-module, angle_sequencer:
  - Owns the index, the direction register and the angle arithmetic.
  - Inputs: advance strobe, sweep enable.
  - Output: signed angle.

Test Plan:
Bench parameters for all scenarios: PERIOD_CYCLES=1000, BURST_CYCLES=100, BLANK_CYCLES=50, SAMPLE_DIV=10, CONFIRM_COUNT=3, NUM_ANGLES=3, ANGLE_MIN=-10, ANGLE_STEP=10. Samples are valid on every trigger with a 1-cycle delay.
- Basic hit: threshold=5000; samples above threshold from timer 300 onward; ready held high → one record {angle=-10, tof=301, hit=1}; burst_out high for exactly 100 cycles; next burst_start_out 1000 cycles after the first.
- Blanking and confirmation: above-threshold samples at timer 121 and 141 (both in BLANK) → ignored. Two above-threshold samples at 201 and 211, then one below → run clears. Three consecutive from 401 → tof=401, hit=1.
- Timeout: all samples below threshold → result_valid_out rises the cycle after timer=999 with hit=0, tof=0; next ping starts one cycle after acceptance.
- Back-pressure: ready held low for 2000 cycles → record stable, no burst_out, busy_out=1; ready pulse → the following ping uses angle 0.
- Sweep order: five pings with sweep_en_in=1 → angles -10,0,10,-10,0 without the macro; -10,0,10,0,-10 with PING_SCAN_BOUNCE_EN.
- Async reset mid-LISTEN: rst_n low for 3 cycles → all outputs 0 immediately; state IDLE; next ping starts at angle -10.
